// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - handshake, register-file and operand signals of writeback_unit
interface writeback_unit_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
);
   logic                     AluValid;
   logic                     AluReady;
   logic [REG_AW-1:0]        AluRD;
   logic [DATA_W-1:0]        AluData;
   logic                     MemValid;
   logic                     MemReady;
   logic [REG_AW-1:0]        MemRD;
   logic [DATA_W-1:0]        MemData;
   logic                     IssueValid;
   logic [REG_AW-1:0]        IssueRD;
   logic [REG_AW-1:0]        RS;
   logic [REG_AW-1:0]        RT;
   logic [DATA_W-1:0]        ReadRS;
   logic [DATA_W-1:0]        ReadRT;
   logic [REG_AW-1:0]        RD;
   logic [DATA_W-1:0]        WriteData;
   logic                     RegWrite;
   logic [(1<<REG_AW)-1:0]   Busy;
   logic                     HazardRS;
   logic                     HazardRT;
   logic [DATA_W-1:0]        OperandRS;
   logic [DATA_W-1:0]        OperandRT;

   // producer/decode side: offers results, issues, reads operands
   modport master (
      output AluValid, AluRD, AluData, MemValid, MemRD, MemData,
      output IssueValid, IssueRD, RS, RT, ReadRS, ReadRT,
      input  AluReady, MemReady, RD, WriteData, RegWrite, Busy,
      input  HazardRS, HazardRT, OperandRS, OperandRT
   );

   // writeback unit side
   modport slave (
      input  AluValid, AluRD, AluData, MemValid, MemRD, MemData,
      input  IssueValid, IssueRD, RS, RT, ReadRS, ReadRT,
      output AluReady, MemReady, RD, WriteData, RegWrite, Busy,
      output HazardRS, HazardRT, OperandRS, OperandRT
   );
endinterface

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - round-robin writeback merge with busy scoreboard; optional forwarding via WB_FORWARD_EN
module writeback_unit #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic             Clock,
   input  logic             ResetN,
   writeback_unit_if.slave  wb
);
   localparam int NREG = 1 << REG_AW;

   logic                last_mem_q, last_mem_d;   // 1: last grant went to the load path
   logic [REG_AW-1:0]   rd_q, rd_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                regwrite_q, regwrite_d;
   logic [NREG-1:0]     busy_q, busy_d;
   logic                grant_alu, grant_mem;
   logic                fwd_rs, fwd_rt;

   // round-robin pick: a lone requester wins, a tie goes to the port not granted last
   always_comb begin
      grant_alu = wb.AluValid && (!wb.MemValid || last_mem_q);
      grant_mem = wb.MemValid && (!wb.AluValid || !last_mem_q);
   end

   assign wb.AluReady = grant_alu;
   assign wb.MemReady = grant_mem;

   // output register and arbitration history next state; RD/data hold when idle
   always_comb begin
      last_mem_d = last_mem_q;
      rd_d       = rd_q;
      wdata_d    = wdata_q;
      regwrite_d = 1'b0;
      if (grant_alu) begin
         last_mem_d = 1'b0;
         rd_d       = wb.AluRD;
         wdata_d    = wb.AluData;
         regwrite_d = 1'b1;
      end else if (grant_mem) begin
         last_mem_d = 1'b1;
         rd_d       = wb.MemRD;
         wdata_d    = wb.MemData;
         regwrite_d = 1'b1;
      end
   end

   // scoreboard next state: a new issue wins over the retiring write to the same register
   always_comb begin
      busy_d = busy_q;
      for (int n = 0; n < NREG; n++) begin
         if (wb.IssueValid && (wb.IssueRD == REG_AW'(n)))
            busy_d[n] = 1'b1;
         else if (regwrite_q && (rd_q == REG_AW'(n)))
            busy_d[n] = 1'b0;
      end
   end

   // state registers; reset drops any write still sitting in the output register
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         last_mem_q <= 1'b1;
         rd_q       <= '0;
         wdata_q    <= '0;
         regwrite_q <= 1'b0;
         busy_q     <= '0;
      end else begin
         last_mem_q <= last_mem_d;
         rd_q       <= rd_d;
         wdata_q    <= wdata_d;
         regwrite_q <= regwrite_d;
         busy_q     <= busy_d;
      end
   end

`ifdef WB_FORWARD_EN
   // the write being committed this cycle is visible to decode immediately
   assign fwd_rs = regwrite_q && (rd_q == wb.RS);
   assign fwd_rt = regwrite_q && (rd_q == wb.RT);
`else
   assign fwd_rs = 1'b0;
   assign fwd_rt = 1'b0;
`endif

   assign wb.RD        = rd_q;
   assign wb.WriteData = wdata_q;
   assign wb.RegWrite  = regwrite_q;
   assign wb.Busy      = busy_q;
   assign wb.HazardRS  = busy_q[wb.RS] && !fwd_rs;
   assign wb.HazardRT  = busy_q[wb.RT] && !fwd_rt;
   assign wb.OperandRS = fwd_rs ? wdata_q : wb.ReadRS;
   assign wb.OperandRT = fwd_rt ? wdata_q : wb.ReadRT;
endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - randomized and directed bench for writeback_unit against a behavioural model
module tb_writeback_unit;
   logic Clock  = 1'b0;
   logic ResetN = 1'b0;

   writeback_unit_if #(.DATA_W(16), .REG_AW(3)) wb_bus ();
   writeback_unit #(.DATA_W(16), .REG_AW(3)) dut (.Clock(Clock), .ResetN(ResetN), .wb(wb_bus));

   always #5 Clock = ~Clock;

   int n_cmp  = 0;
   int n_fail = 0;
   int wr5    = 0;
   bit chk_en = 1'b0;

   // model of the architectural state: pending write, scoreboard, who won last
   bit        m_rw = 1'b0;
   bit [2:0]  m_rd = 3'd0;
   bit [15:0] m_wd = 16'h0;
   bit [7:0]  m_busy = 8'h00;
   bit        m_last_mem = 1'b1;
   bit        alu_pend = 1'b0;
   bit        mem_pend = 1'b0;
   bit [1:0]  g;
   bit [1:0]  e;
   bit        fr, ft;

   logic [15:0] arb_wd [4] = '{16'hA001, 16'hB001, 16'hA002, 16'hB002};
   logic [2:0]  arb_rd [4] = '{3'd1, 3'd2, 3'd1, 3'd2};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // {alu, mem}: a lone requester wins; with both requesting, the one not served last
   function automatic bit [1:0] winner(input bit av, input bit mv, input bit last_was_mem);
      if (av && mv) return last_was_mem ? 2'b10 : 2'b01;
      if (av)       return 2'b10;
      if (mv)       return 2'b01;
      return 2'b00;
   endfunction

   always @(posedge Clock) begin
      if (ResetN) begin
         if (m_rw) m_busy[m_rd] = 1'b0;
         if (wb_bus.IssueValid === 1'b1) m_busy[wb_bus.IssueRD] = 1'b1;
         g    = winner(wb_bus.AluValid, wb_bus.MemValid, m_last_mem);
         m_rw = |g;
         if (g[1]) begin
            m_rd = wb_bus.AluRD; m_wd = wb_bus.AluData; m_last_mem = 1'b0; alu_pend = 1'b0;
         end else if (g[0]) begin
            m_rd = wb_bus.MemRD; m_wd = wb_bus.MemData; m_last_mem = 1'b1; mem_pend = 1'b0;
         end
      end
   end

   always @(negedge ResetN) begin
      m_rw = 1'b0; m_rd = 3'd0; m_wd = 16'h0; m_busy = 8'h00; m_last_mem = 1'b1;
   end

   always @(negedge Clock) begin
      if (chk_en) begin
         e = winner(wb_bus.AluValid, wb_bus.MemValid, m_last_mem);
         fr = 1'b0;
         ft = 1'b0;
`ifdef WB_FORWARD_EN
         fr = m_rw && (m_rd == wb_bus.RS);
         ft = m_rw && (m_rd == wb_bus.RT);
`endif
         chk("alu_ready", 32'(wb_bus.AluReady), 32'(e[1]));
         chk("mem_ready", 32'(wb_bus.MemReady), 32'(e[0]));
         chk("regwrite",  32'(wb_bus.RegWrite), 32'(m_rw));
         chk("rd",        32'(wb_bus.RD), 32'(m_rd));
         chk("wdata",     32'(wb_bus.WriteData), 32'(m_wd));
         chk("busy",      32'(wb_bus.Busy), 32'(m_busy));
         chk("hazard_rs", 32'(wb_bus.HazardRS), 32'(m_busy[wb_bus.RS] && !fr));
         chk("hazard_rt", 32'(wb_bus.HazardRT), 32'(m_busy[wb_bus.RT] && !ft));
         chk("operand_rs", 32'(wb_bus.OperandRS), 32'(fr ? m_wd : wb_bus.ReadRS));
         chk("operand_rt", 32'(wb_bus.OperandRT), 32'(ft ? m_wd : wb_bus.ReadRT));
         if (wb_bus.RegWrite === 1'b1 && wb_bus.RD === 3'd5) wr5++;
      end
   end

   task automatic next_cycle();
      @(posedge Clock);
      #2;
   endtask

   task automatic idle_inputs();
      wb_bus.AluValid = 1'b0; wb_bus.AluRD = 3'd0; wb_bus.AluData = 16'h0;
      wb_bus.MemValid = 1'b0; wb_bus.MemRD = 3'd0; wb_bus.MemData = 16'h0;
      wb_bus.IssueValid = 1'b0; wb_bus.IssueRD = 3'd0;
      wb_bus.RS = 3'd0; wb_bus.RT = 3'd0; wb_bus.ReadRS = 16'h0; wb_bus.ReadRT = 16'h0;
   endtask

   task automatic do_reset();
      ResetN = 1'b0;
      idle_inputs();
      repeat (2) next_cycle();
      ResetN = 1'b1;
   endtask

   initial begin
      idle_inputs();
      do_reset();
      chk_en = 1'b1;

      // reset asserted while a write and a scoreboard bit are live
      wb_bus.AluValid = 1'b1; wb_bus.AluRD = 3'd6; wb_bus.AluData = 16'h55AA;
      wb_bus.IssueValid = 1'b1; wb_bus.IssueRD = 3'd2;
      next_cycle();
      wb_bus.AluValid = 1'b0; wb_bus.IssueValid = 1'b0;
      #1;
      chk("pre_rst_regwrite", 32'(wb_bus.RegWrite), 32'd1);
      chk("pre_rst_busy", 32'(wb_bus.Busy), 32'h04);
      ResetN = 1'b0;
      #1;
      chk("rst_regwrite", 32'(wb_bus.RegWrite), 32'd0);
      chk("rst_rd", 32'(wb_bus.RD), 32'd0);
      chk("rst_wdata", 32'(wb_bus.WriteData), 32'h0);
      chk("rst_busy", 32'(wb_bus.Busy), 32'h00);
      next_cycle();
      ResetN = 1'b1;
      wb_bus.AluValid = 1'b1; wb_bus.AluRD = 3'd3; wb_bus.AluData = 16'h1234;
      @(negedge Clock);
      chk("rel_alu_ready", 32'(wb_bus.AluReady), 32'd1);
      next_cycle();
      wb_bus.AluValid = 1'b0;
      #1;
      chk("rel_regwrite", 32'(wb_bus.RegWrite), 32'd1);
      chk("rel_rd", 32'(wb_bus.RD), 32'd3);
      chk("rel_wdata", 32'(wb_bus.WriteData), 32'h1234);

      // both ports continuously valid: ALU first after reset, then alternate
      do_reset();
      wb_bus.AluValid = 1'b1; wb_bus.AluRD = 3'd1; wb_bus.AluData = 16'hA001;
      wb_bus.MemValid = 1'b1; wb_bus.MemRD = 3'd2; wb_bus.MemData = 16'hB001;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         chk("arb_alu_ready", 32'(wb_bus.AluReady), 32'(i % 2 == 0));
         chk("arb_mem_ready", 32'(wb_bus.MemReady), 32'(i % 2 == 1));
         next_cycle();
         if (i % 2 == 0) begin
            wb_bus.AluData = 16'hA002;
            if (i == 2) wb_bus.AluValid = 1'b0;
         end else begin
            wb_bus.MemData = 16'hB002;
            if (i == 3) wb_bus.MemValid = 1'b0;
         end
         #1;
         chk("arb_wdata", 32'(wb_bus.WriteData), 32'(arb_wd[i]));
         chk("arb_rd", 32'(wb_bus.RD), 32'(arb_rd[i]));
      end

      // load path loses one tie and must hold its offer
      wr5 = 0;
      wb_bus.AluValid = 1'b1; wb_bus.AluRD = 3'd1; wb_bus.AluData = 16'h1111;
      wb_bus.MemValid = 1'b1; wb_bus.MemRD = 3'd5; wb_bus.MemData = 16'h00FF;
      @(negedge Clock);
      chk("bp_mem_wait", 32'(wb_bus.MemReady), 32'd0);
      next_cycle();
      wb_bus.AluData = 16'h2222;
      #1;
      chk("bp_alu_first", 32'(wb_bus.WriteData), 32'h1111);
      @(negedge Clock);
      chk("bp_mem_ready", 32'(wb_bus.MemReady), 32'd1);
      chk("bp_alu_wait", 32'(wb_bus.AluReady), 32'd0);
      next_cycle();
      wb_bus.MemValid = 1'b0;
      #1;
      chk("bp_mem_wdata", 32'(wb_bus.WriteData), 32'h00FF);
      chk("bp_mem_rd", 32'(wb_bus.RD), 32'd5);
      next_cycle();
      wb_bus.AluValid = 1'b0;
      #1;
      chk("bp_alu_second", 32'(wb_bus.WriteData), 32'h2222);
      next_cycle();
      chk("bp_r5_writes", 32'(wr5), 32'd1);

      // scoreboard lifetime, forwarding window and same-edge re-issue
      wb_bus.IssueValid = 1'b1; wb_bus.IssueRD = 3'd4;
      next_cycle();
      wb_bus.IssueValid = 1'b0;
      #1;
      chk("sb_set", 32'(wb_bus.Busy[4]), 32'd1);
      next_cycle();
      next_cycle();
      #1;
      chk("sb_hold", 32'(wb_bus.Busy[4]), 32'd1);
      wb_bus.AluValid = 1'b1; wb_bus.AluRD = 3'd4; wb_bus.AluData = 16'hBEEF;
      wb_bus.RS = 3'd4; wb_bus.ReadRS = 16'h0000;
      next_cycle();
      wb_bus.AluValid = 1'b0;
      wb_bus.IssueValid = 1'b1; wb_bus.IssueRD = 3'd4;
      #1;
      chk("sb_wb_busy", 32'(wb_bus.Busy[4]), 32'd1);
      chk("sb_wb_rd", 32'(wb_bus.RD), 32'd4);
`ifdef WB_FORWARD_EN
      chk("fwd_operand", 32'(wb_bus.OperandRS), 32'hBEEF);
      chk("fwd_hazard", 32'(wb_bus.HazardRS), 32'd0);
`else
      chk("nofwd_operand", 32'(wb_bus.OperandRS), 32'h0000);
      chk("nofwd_hazard", 32'(wb_bus.HazardRS), 32'd1);
`endif
      next_cycle();
      wb_bus.IssueValid = 1'b0;
      #1;
      chk("sb_reissue", 32'(wb_bus.Busy[4]), 32'd1);
      wb_bus.AluValid = 1'b1; wb_bus.AluData = 16'h0001;
      next_cycle();
      wb_bus.AluValid = 1'b0;
      #1;
      chk("sb_pending", 32'(wb_bus.Busy[4]), 32'd1);
      next_cycle();
      chk("sb_clear", 32'(wb_bus.Busy[4]), 32'd0);

      // both paths target R0 in the same cycle
      do_reset();
      wb_bus.AluValid = 1'b1; wb_bus.AluRD = 3'd0; wb_bus.AluData = 16'h0A0A;
      wb_bus.MemValid = 1'b1; wb_bus.MemRD = 3'd0; wb_bus.MemData = 16'h0B0B;
      next_cycle();
      wb_bus.AluValid = 1'b0;
      #1;
      chk("r0_first", 32'(wb_bus.WriteData), 32'h0A0A);
      chk("r0_first_we", 32'(wb_bus.RegWrite), 32'd1);
      next_cycle();
      wb_bus.MemValid = 1'b0;
      #1;
      chk("r0_second", 32'(wb_bus.WriteData), 32'h0B0B);
      chk("r0_second_rd", 32'(wb_bus.RD), 32'd0);
      next_cycle();
      chk("r0_idle_we", 32'(wb_bus.RegWrite), 32'd0);
      chk("r0_final", 32'(wb_bus.WriteData), 32'h0B0B);

      // randomized traffic; sources hold their offer until the model says it was taken
      alu_pend = 1'b0;
      mem_pend = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset();
            alu_pend = 1'b0;
            mem_pend = 1'b0;
         end
         if (!alu_pend && $urandom_range(0, 2) == 0) begin
            alu_pend = 1'b1; wb_bus.AluRD = 3'($urandom); wb_bus.AluData = 16'($urandom);
         end
         if (!mem_pend && $urandom_range(0, 2) == 0) begin
            mem_pend = 1'b1; wb_bus.MemRD = 3'($urandom); wb_bus.MemData = 16'($urandom);
         end
         wb_bus.AluValid   = alu_pend;
         wb_bus.MemValid   = mem_pend;
         wb_bus.IssueValid = ($urandom_range(0, 3) == 0);
         wb_bus.IssueRD    = 3'($urandom);
         wb_bus.RS         = 3'($urandom);
         wb_bus.RT         = 3'($urandom);
         wb_bus.ReadRS     = 16'($urandom);
         wb_bus.ReadRT     = 16'($urandom);
         next_cycle();
      end

      @(negedge Clock);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
